// File: rtl/alu_pkg.sv
// Shared opcode/select encodings, FIFO state and decoded-operation record
// for the ALU operand control stage.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_RSUB = 4'd7;

    localparam logic [1:0] SEL_ADD = 2'd0;
    localparam logic [1:0] SEL_AND = 2'd1;
    localparam logic [1:0] SEL_OR  = 2'd2;
    localparam logic [1:0] SEL_SLT = 2'd3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_t;

    // Decoded control half of a stored entry; operands are added per WIDTH.
    typedef struct packed {
        logic       inv_x;
        logic       inv_y;
        logic       cin;
        logic [1:0] sel;
    } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode -> EX-stage invert/carry/select controls; purely combinational.
// Opcodes with bit 3 set are flagged illegal and decode to all zeros.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] op,
    output dec_t       dec,
    output logic       illegal
);

    always_comb begin
        dec     = '0;
        illegal = op[3];
        case (op)
            OP_ADD:  dec = '{1'b0, 1'b0, 1'b0, SEL_ADD};
            OP_SUB:  dec = '{1'b0, 1'b1, 1'b1, SEL_ADD};
            OP_AND:  dec = '{1'b0, 1'b0, 1'b0, SEL_AND};
            OP_OR:   dec = '{1'b0, 1'b0, 1'b0, SEL_OR};
            // NOR/NAND reuse AND/OR on inverted operands (De Morgan)
            OP_NOR:  dec = '{1'b1, 1'b1, 1'b0, SEL_AND};
            OP_NAND: dec = '{1'b1, 1'b1, 1'b0, SEL_OR};
            OP_SLT:  dec = '{1'b0, 1'b1, 1'b1, SEL_SLT};
            OP_RSUB: dec = '{1'b1, 1'b0, 1'b1, SEL_ADD};
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/alu_operand_ctrl.sv
// Decodes ID ops into a 2-entry skid FIFO feeding EX; 1-cycle latency when empty.
// Backpressure: in_ready (registered) drops only when both entries are held.
module alu_operand_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic             out_inv_x,
    output logic             out_inv_y,
    output logic             out_cin,
    output logic [1:0]       out_sel,
    output logic             out_illegal
);

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        dec_t             dec;
    } entry_t;

    fifo_state_t state;
    fifo_state_t state_nxt;
    entry_t      head;
    entry_t      tail;
    entry_t      in_ent;
    dec_t        in_dec;
    logic        in_illegal;
    logic        accept;
    logic        consume;
    logic        push;

    alu_op_decode u_decode (
        .op      (in_op),
        .dec     (in_dec),
        .illegal (in_illegal)
    );

    assign in_ent  = '{x: in_x, y: in_y, dec: in_dec};
    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;
    // Illegal ops complete the handshake but never occupy a slot
    assign push    = accept & ~in_illegal;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (push) state_nxt = ST_ONE;
            ST_ONE: begin
                if (push && !consume)      state_nxt = ST_FULL;
                else if (!push && consume) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (consume) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_EMPTY;
            in_ready    <= 1'b1;
            out_illegal <= 1'b0;
            head        <= '0;
            tail        <= '0;
        end else if (flush) begin
            state       <= ST_EMPTY;
            in_ready    <= 1'b1;
            out_illegal <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready    <= (state_nxt != ST_FULL);
            out_illegal <= accept & in_illegal;
            if (consume) begin
                // FULL shifts the tail forward; ONE refills from input (or goes empty)
                head <= (state == ST_FULL) ? tail : in_ent;
            end else if (push && state == ST_EMPTY) begin
                head <= in_ent;
            end
            if (push && !consume && state == ST_ONE) begin
                tail <= in_ent;
            end
        end
    end

    assign out_valid = (state != ST_EMPTY);

    always_comb begin
        out_x     = '0;
        out_y     = '0;
        out_inv_x = 1'b0;
        out_inv_y = 1'b0;
        out_cin   = 1'b0;
        out_sel   = SEL_ADD;
        if (out_valid) begin
            out_x     = head.x;
            out_y     = head.y;
            out_inv_x = head.dec.inv_x;
            out_inv_y = head.dec.inv_y;
            out_cin   = head.dec.cin;
            out_sel   = head.dec.sel;
        end
    end

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Bench for alu_operand_ctrl: opcode table, handshake corner sequences,
// then random traffic against a queue-based reference.
module tb_alu_operand_ctrl;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic         out_inv_x, out_inv_y, out_cin, out_illegal;
    logic [3:0]   in_op;
    logic [W-1:0] in_x, in_y, out_x, out_y;
    logic [1:0]   out_sel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_operand_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_x        (in_x),
        .in_y        (in_y),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_inv_x   (out_inv_x),
        .out_inv_y   (out_inv_y),
        .out_cin     (out_cin),
        .out_sel     (out_sel),
        .out_illegal (out_illegal)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [4:0]   exp_dec;   // {inv_x, inv_y, cin, sel}
        logic         exp_ill;
    } vec_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } op_t;

    vec_t tbl [16];
    op_t  q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Operation semantics as listed in the opcode table
    function automatic logic [4:0] ref_dec(input logic [3:0] op);
        case (op)
            4'd0:    return 5'b000_00;
            4'd1:    return 5'b011_00;
            4'd2:    return 5'b000_01;
            4'd3:    return 5'b000_10;
            4'd4:    return 5'b110_01;
            4'd5:    return 5'b110_10;
            4'd6:    return 5'b011_11;
            4'd7:    return 5'b101_00;
            default: return 5'b000_00;
        endcase
    endfunction

    function automatic logic [31:0] dec_bits();
        return 32'({out_inv_x, out_inv_y, out_cin, out_sel});
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_x      = '0;
        in_y      = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic offer(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        in_op    = op;
        in_x     = x;
        in_y     = y;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc, con, ill_m;
        logic [W-1:0] held_x;

        tbl[0] = '{OP_ADD,  16'h1234, 16'h0F0F, 5'b000_00, 1'b0};
        tbl[1] = '{OP_SUB,  16'h0005, 16'h0003, 5'b011_00, 1'b0};
        tbl[2] = '{OP_AND,  16'hAAAA, 16'h5555, 5'b000_01, 1'b0};
        tbl[3] = '{OP_OR,   16'h00FF, 16'hFF00, 5'b000_10, 1'b0};
        tbl[4] = '{OP_NOR,  16'hDEAD, 16'hBEEF, 5'b110_01, 1'b0};
        tbl[5] = '{OP_NAND, 16'h8001, 16'h7FFE, 5'b110_10, 1'b0};
        tbl[6] = '{OP_SLT,  16'hFFFF, 16'h0001, 5'b011_11, 1'b0};
        tbl[7] = '{OP_RSUB, 16'h0100, 16'h0010, 5'b101_00, 1'b0};
        for (int i = 8; i < 16; i++)
            tbl[i] = '{4'(i), 16'(16'h4000 + i), 16'(16'h0400 + i), 5'b000_00, 1'b1};

        // Reset state
        do_reset();
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_illegal",   32'(out_illegal), 32'd0);
        chk("rst_out_x",     32'(out_x),       32'd0);
        chk("rst_out_y",     32'(out_y),       32'd0);
        chk("rst_dec",       dec_bits(),       32'd0);

        // SUB X=5 Y=3 presented next cycle
        out_ready = 1'b1;
        offer(OP_SUB, 16'h0005, 16'h0003);
        step();
        in_valid = 1'b0;
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_inv_y", 32'(out_inv_y), 32'd1);
        chk("sub_cin",   32'(out_cin),   32'd1);
        chk("sub_sel",   32'(out_sel),   32'(SEL_ADD));
        chk("sub_x",     32'(out_x),     32'h0005);
        step();
        chk("sub_drained", 32'(out_valid), 32'd0);

        // Opcode table, one op at a time through an empty FIFO
        for (int i = 0; i < 16; i++) begin
            out_ready = 1'b1;
            offer(tbl[i].op, tbl[i].x, tbl[i].y);
            step();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", i),   32'(out_valid),   32'(!tbl[i].exp_ill));
            chk($sformatf("tbl%0d_illegal", i), 32'(out_illegal), 32'(tbl[i].exp_ill));
            chk($sformatf("tbl%0d_dec", i),     dec_bits(),       32'(tbl[i].exp_dec));
            chk($sformatf("tbl%0d_x", i), 32'(out_x), tbl[i].exp_ill ? 32'd0 : 32'(tbl[i].x));
            chk($sformatf("tbl%0d_y", i), 32'(out_y), tbl[i].exp_ill ? 32'd0 : 32'(tbl[i].y));
            step();
            chk($sformatf("tbl%0d_after", i), 32'({out_valid, out_illegal}), 32'd0);
        end

        // Backpressure: fill to FULL, third op refused, head holds
        out_ready = 1'b0;
        offer(OP_ADD, 16'h0A0A, 16'h0001);
        step();
        chk("bp1_in_ready", 32'(in_ready), 32'd1);
        chk("bp1_x",        32'(out_x),    32'h0A0A);
        offer(OP_NOR, 16'h0B0B, 16'h0002);
        step();
        chk("bp2_in_ready", 32'(in_ready), 32'd0);
        chk("bp2_x",        32'(out_x),    32'h0A0A);
        chk("bp2_sel",      32'(out_sel),  32'(SEL_ADD));
        offer(OP_SLT, 16'h0C0C, 16'h0003);
        step();
        chk("bp3_in_ready", 32'(in_ready),  32'd0);
        chk("bp3_valid",    32'(out_valid), 32'd1);
        chk("bp3_x",        32'(out_x),     32'h0A0A);
        chk("bp3_dec",      dec_bits(),     32'(ref_dec(OP_ADD)));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_drain_nor_x",   32'(out_x),  32'h0B0B);
        chk("bp_drain_nor_dec", dec_bits(),  32'(ref_dec(OP_NOR)));
        step();
        chk("bp_drain_empty",   32'(out_valid), 32'd0);

        // Steady state ONE: accept + consume every cycle
        out_ready = 1'b0;
        offer(OP_ADD, 16'd100, 16'd0);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(4'(i % 8), 16'(200 + i), 16'(i));
            step();
            chk($sformatf("thru%0d_in_ready", i), 32'(in_ready),  32'd1);
            chk($sformatf("thru%0d_valid", i),    32'(out_valid), 32'd1);
            chk($sformatf("thru%0d_x", i),        32'(out_x),     32'(200 + i));
            chk($sformatf("thru%0d_dec", i),      dec_bits(),     32'(ref_dec(4'(i % 8))));
        end
        in_valid = 1'b0;
        step();
        chk("thru_empty", 32'(out_valid), 32'd0);

        // Illegal opcode pulses out_illegal for exactly one cycle
        offer(4'hC, 16'h1111, 16'h2222);
        step();
        in_valid = 1'b0;
        chk("ill_pulse",    32'(out_illegal), 32'd1);
        chk("ill_valid",    32'(out_valid),   32'd0);
        chk("ill_in_ready", 32'(in_ready),    32'd1);
        step();
        chk("ill_pulse_end", 32'(out_illegal), 32'd0);

        // Flush in FULL with a simultaneous offer
        out_ready = 1'b0;
        offer(OP_ADD, 16'h0011, 16'h0);
        step();
        offer(OP_OR, 16'h0022, 16'h0);
        step();
        chk("fl_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        // one drained; refill to FULL, then flush with an offer pending
        out_ready = 1'b0;
        offer(OP_AND, 16'h0044, 16'h0);
        step();
        offer(OP_ADD, 16'h0033, 16'h0);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid",    32'(out_valid),   32'd0);
        chk("fl_in_ready", 32'(in_ready),    32'd1);
        chk("fl_illegal",  32'(out_illegal), 32'd0);
        out_ready = 1'b1;
        step();
        chk("fl_no_ghost", 32'(out_valid), 32'd0);

        // Reset in FULL with out_ready high
        out_ready = 1'b0;
        offer(OP_SUB, 16'h0055, 16'h0);
        step();
        offer(OP_NAND, 16'h0066, 16'h0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        chk("rf_valid",    32'(out_valid),   32'd0);
        chk("rf_in_ready", 32'(in_ready),    32'd1);
        chk("rf_illegal",  32'(out_illegal), 32'd0);
        chk("rf_data",     32'({out_x, out_y} != '0), 32'd0);
        chk("rf_dec",      dec_bits(),       32'd0);
        step();
        chk("rf_stays_empty", 32'(out_valid), 32'd0);

        // Random traffic against a queue reference
        do_reset();
        q.delete();
        ill_m = 1'b0;
        for (int c = 0; c < 600; c++) begin
            chk("rnd_in_ready", 32'(in_ready),    32'(q.size() < 2));
            chk("rnd_valid",    32'(out_valid),   32'(q.size() > 0));
            chk("rnd_illegal",  32'(out_illegal), 32'(ill_m));
            if (q.size() > 0) begin
                chk("rnd_x",   32'(out_x), 32'(q[0].x));
                chk("rnd_y",   32'(out_y), 32'(q[0].y));
                chk("rnd_dec", dec_bits(), 32'(ref_dec(q[0].op)));
            end else begin
                chk("rnd_idle_data", 32'({out_x, out_y} != '0) | dec_bits(), 32'd0);
            end

            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15))
                                                    : 4'($urandom_range(0, 7));
            in_x      = W'($urandom);
            in_y      = W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            acc = in_valid && (q.size() < 2);
            con = out_ready && (q.size() > 0);
            held_x = in_x;
            step();
            if (flush) begin
                q.delete();
                ill_m = 1'b0;
            end else begin
                ill_m = acc && (in_op >= 4'd8);
                if (con) void'(q.pop_front());
                if (acc && in_op < 4'd8) q.push_back('{in_op, held_x, in_y});
            end
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
